// File: rtl/divider_pkg.sv
// Shared definitions for the sequential divider: FSM states, default width
// and the iteration-counter width.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int unsigned DIV_WIDTH = 4;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider4_if.sv
// Start/done handshake plus operand and result buses of the sequential divider.
interface seq_divider4_if #(
  parameter int unsigned WIDTH = divider_pkg::DIV_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             DivByZero;

  modport master (
    output start, Dividend, Divisor,
    input  busy, done, Quotient, Remainder, DivByZero
  );

  modport slave (
    input  start, Dividend, Divisor,
    output busy, done, Quotient, Remainder, DivByZero
  );
endinterface

// File: rtl/addsub_unit.sv
// Ripple-carry add/subtract: Sum = A + (B ^ {M}) + M, so M=1 subtracts.
module addsub_unit #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  logic c;
  logic bx;

  always_comb begin
    c   = M;
    bx  = 1'b0;
    Sum = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      bx     = B[i] ^ M;
      Sum[i] = A[i] ^ bx ^ c;
      c      = (A[i] & bx) | (A[i] & c) | (bx & c);
    end
    Carry = c;
  end

endmodule

// File: rtl/seq_divider4.sv
// Multi-cycle non-restoring unsigned divider with start/done handshake.
// Optional divide-by-zero fast path enabled by defining DIV_ZERO_DETECT_EN.
module seq_divider4
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input logic           clk,
  input logic           rst,
  seq_divider4_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH:0]     p_q, p_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;
`ifdef DIV_ZERO_DETECT_EN
  logic               zdiv_q, zdiv_d;
`endif

  logic [WIDTH:0]     as_a, as_b, as_sum;
  logic               as_m;
  logic               as_carry_unused;

  addsub_unit #(.WIDTH(WIDTH + 1)) u_addsub (
    .A     (as_a),
    .B     (as_b),
    .M     (as_m),
    .Sum   (as_sum),
    .Carry (as_carry_unused)
  );

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
    zdiv_d  = zdiv_q;
`endif
    // ITER operands by default: shifted partial remainder against the divisor
    as_a    = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    as_b    = {1'b0, d_q};
    as_m    = ~p_q[WIDTH];

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          p_d     = '0;
          q_d     = bus.Dividend;
          d_d     = bus.Divisor;
          cnt_d   = '0;
          state_d = ITER;
`ifdef DIV_ZERO_DETECT_EN
          zdiv_d  = (bus.Divisor == '0);
          if (bus.Divisor == '0) state_d = FIX;
`endif
        end
      end
      ITER: begin
        p_d   = as_sum;
        q_d   = {q_q[WIDTH-2:0], ~as_sum[WIDTH]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        as_a    = p_q;
        as_b    = p_q[WIDTH] ? {1'b0, d_q} : '0;
        as_m    = 1'b0;
        p_d     = as_sum;
        quot_d  = q_q;
        rem_d   = as_sum[WIDTH-1:0];
        dbz_d   = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef DIV_ZERO_DETECT_EN
        // Fast path: q_q still holds the untouched dividend
        if (zdiv_q) begin
          quot_d = '1;
          rem_d  = q_q;
          dbz_d  = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      zdiv_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
`ifdef DIV_ZERO_DETECT_EN
      zdiv_q  <= zdiv_d;
`endif
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.Quotient  = quot_q;
  assign bus.Remainder = rem_q;
  assign bus.DivByZero = dbz_q;

endmodule

// File: tb/tb_seq_divider4.sv
// Directed-vector bench for seq_divider4; expectations follow the build's
// DIV_ZERO_DETECT_EN setting.
module tb_seq_divider4;

  localparam int unsigned W = 4;
`ifdef DIV_ZERO_DETECT_EN
  localparam int ZLAT  = 1;
  localparam int ZFLAG = 1;
`else
  localparam int ZLAT  = 5;
  localparam int ZFLAG = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_divider4_if #(.WIDTH(W)) bus ();
  seq_divider4 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int overlap  = 0;

  always @(posedge clk) if (bus.done) done_cnt <= done_cnt + 1;
  always @(negedge clk) if (bus.done && bus.busy) overlap <= overlap + 1;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int z;
    int lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called just after an active edge; returns just after the done edge.
  task automatic run_div(input int a, input int b, output int q, output int r,
                         output int z, output int lat, output int busy_ok);
    logic [W-1:0] av;
    logic [W-1:0] bv;
    av = a[W-1:0];
    bv = b[W-1:0];
    bus.start    = 1'b1;
    bus.Dividend = av;
    bus.Divisor  = bv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    busy_ok = 1;
    while (!bus.done && lat < 20) begin
      if (!bus.busy) busy_ok = 0;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.busy) busy_ok = 0;
    q = int'(bus.Quotient);
    r = int'(bus.Remainder);
    z = int'(bus.DivByZero);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int q, r, z, lat, bok, snap, eq, er, el;

    vecs[0] = '{a: 13, b: 4,  q: 3,  r: 1, z: 0,     lat: 5};
    vecs[1] = '{a: 15, b: 1,  q: 15, r: 0, z: 0,     lat: 5};
    vecs[2] = '{a: 7,  b: 9,  q: 0,  r: 7, z: 0,     lat: 5};
    vecs[3] = '{a: 0,  b: 5,  q: 0,  r: 0, z: 0,     lat: 5};
    vecs[4] = '{a: 9,  b: 0,  q: 15, r: 9, z: ZFLAG, lat: ZLAT};
    vecs[5] = '{a: 15, b: 15, q: 1,  r: 0, z: 0,     lat: 5};
    vecs[6] = '{a: 14, b: 3,  q: 4,  r: 2, z: 0,     lat: 5};
    vecs[7] = '{a: 1,  b: 15, q: 0,  r: 1, z: 0,     lat: 5};
    vecs[8] = '{a: 12, b: 5,  q: 2,  r: 2, z: 0,     lat: 5};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.Dividend = '0;
    bus.Divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset Q", int'(bus.Quotient), 0);
    check("reset R", int'(bus.Remainder), 0);
    check("reset DivByZero", int'(bus.DivByZero), 0);

    for (int i = 0; i < 9; i++) begin
      run_div(vecs[i].a, vecs[i].b, q, r, z, lat, bok);
      check($sformatf("vec%0d Q", i), q, vecs[i].q);
      check($sformatf("vec%0d R", i), r, vecs[i].r);
      check($sformatf("vec%0d DivByZero", i), z, vecs[i].z);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d busy profile", i), bok, 1);
      @(posedge clk); #1;
      check($sformatf("vec%0d done pulse width", i), int'(bus.done), 0);
    end

    // Starts while busy (including the FIX edge) are ignored
    bus.start = 1'b1;
    bus.Dividend = 4'd12;
    bus.Divisor = 4'd5;
    @(posedge clk); #1;
    for (int e = 1; e <= 5; e++) begin
      bus.start = (e == 2 || e == 5);
      bus.Dividend = 4'd3;
      bus.Divisor = 4'd1;
      @(posedge clk); #1;
      if (e < 5) check($sformatf("ignore busy e%0d", e), int'(bus.busy), 1);
    end
    bus.start = 1'b0;
    check("ignore done", int'(bus.done), 1);
    check("ignore Q", int'(bus.Quotient), 2);
    check("ignore R", int'(bus.Remainder), 2);
    @(posedge clk); #1;
    snap = done_cnt;
    repeat (12) @(posedge clk);
    #1;
    check("ignore no second done", done_cnt - snap, 0);
    check("ignore idle busy", int'(bus.busy), 0);

    // Reset on the second iteration edge discards the division
    bus.start = 1'b1;
    bus.Dividend = 4'd14;
    bus.Divisor = 4'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst busy", int'(bus.busy), 0);
    check("midrst done", int'(bus.done), 0);
    check("midrst Q", int'(bus.Quotient), 0);
    check("midrst R", int'(bus.Remainder), 0);
    rst = 1'b0;
    snap = done_cnt;
    repeat (8) @(posedge clk);
    #1;
    check("midrst no done", done_cnt - snap, 0);
    run_div(14, 3, q, r, z, lat, bok);
    check("after rst Q", q, 4);
    check("after rst R", r, 2);
    check("after rst latency", lat, 5);

    @(posedge clk); #1;
    snap = done_cnt;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        eq = (b == 0) ? 15 : a / b;
        er = (b == 0) ? a : a % b;
        el = (b == 0) ? ZLAT : 5;
        run_div(a, b, q, r, z, lat, bok);
        check($sformatf("sweep %0d/%0d Q", a, b), q, eq);
        check($sformatf("sweep %0d/%0d R", a, b), r, er);
        check($sformatf("sweep %0d/%0d DivByZero", a, b), z, (b == 0) ? ZFLAG : 0);
        check($sformatf("sweep %0d/%0d latency", a, b), lat, el);
      end
    end
    @(posedge clk); #1;
    check("sweep done count", done_cnt - snap, 256);
    check("done/busy overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
